// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Bit counter width for a WIDTH-bit serial operation (never below 1).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// 1-bit full adder cell: the only arithmetic datapath of the serial unit.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c1,
    output logic f,
    output logic c2
);

    assign f  = a ^ b ^ c1;
    assign c2 = (a & b) | (c1 & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor controller, LSB first, one bit per clock.
// Optional zero-result flag output enabled by defining SERIAL_ADDSUB_ZFLAG_EN.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned      CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_f, fa_c2;
    logic             accept;
    logic             last;

`ifdef SERIAL_ADDSUB_ZFLAG_EN
    logic             any_one;
`endif

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c1 (carry),
        .f  (fa_f),
        .c2 (fa_c2)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand load, serial shifting and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
            any_one  <= 1'b0;
            zero     <= 1'b0;
`endif
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
            any_one <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_f, res_sr[WIDTH-1:1]};
            carry  <= fa_c2;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
            any_one <= any_one | fa_f;
`endif
            if (last) begin
                // carry still holds the carry into the MSB here, so the
                // signed overflow is taken directly against the MSB carry-out.
                result   <= {fa_f, res_sr[WIDTH-1:1]};
                cout     <= fa_c2;
                overflow <= carry ^ fa_c2;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
                zero     <= ~(any_one | fa_f);
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl at WIDTH=8.
module tb_serial_addsub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, cout, overflow;
    logic [7:0] result;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    logic       zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done, sampling on negedges.
    // poke_at >= 0 pulses start with junk operands at that RUN cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                          input int poke_at, output int edges, output int busy_cyc,
                          output logic seen);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0; busy_cyc = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == poke_at) begin
                a = 8'h01; b = 8'h01; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen  = 1'b1;
                edges = i;
                break;
            end
            if (busy) busy_cyc++;
        end
        start = 1'b0;
    endtask

    int   edges, bcyc, dcount;
    logic seen;

    initial begin
        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add 100+27
        run_op(8'd100, 8'd27, 1'b0, -1, edges, bcyc, seen);
        check("add_done_seen", seen, 1);
        check("add_latency", edges, 8);
        check("add_busy_cycles", bcyc, 8);
        check("add_result", result, 127);
        check("add_cout", cout, 0);
        check("add_ovf", overflow, 0);
        check("add_busy_at_done", busy, 0);
        @(negedge clk);
        check("add_done_pulse_width", done, 0);
        check("add_result_held", result, 127);

        // Unsigned carry 200+100
        run_op(8'd200, 8'd100, 1'b0, -1, edges, bcyc, seen);
        check("carry_result", result, 8'h2C);
        check("carry_cout", cout, 1);
        check("carry_ovf", overflow, 0);

        // 5-3
        run_op(8'd5, 8'd3, 1'b1, -1, edges, bcyc, seen);
        check("sub_result", result, 2);
        check("sub_cout", cout, 1);
        check("sub_ovf", overflow, 0);

        // 3-5 borrow
        run_op(8'd3, 8'd5, 1'b1, -1, edges, bcyc, seen);
        check("borrow_result", result, 8'hFE);
        check("borrow_cout", cout, 0);
        check("borrow_ovf", overflow, 0);

        // 0x7F+1 signed overflow
        run_op(8'h7F, 8'h01, 1'b0, -1, edges, bcyc, seen);
        check("ovf_add_result", result, 8'h80);
        check("ovf_add_cout", cout, 0);
        check("ovf_add_ovf", overflow, 1);

        // 0x80-1 signed overflow
        run_op(8'h80, 8'h01, 1'b1, -1, edges, bcyc, seen);
        check("ovf_sub_result", result, 8'h7F);
        check("ovf_sub_cout", cout, 1);
        check("ovf_sub_ovf", overflow, 1);

        // 5-5 gives zero
        run_op(8'd5, 8'd5, 1'b1, -1, edges, bcyc, seen);
        check("zero_result", result, 0);
        check("zero_cout", cout, 1);
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        check("zero_flag", zero, 1);
        run_op(8'd5, 8'd3, 1'b1, -1, edges, bcyc, seen);
        check("zero_flag_clear", zero, 0);
`endif

        // Start during RUN is ignored
        run_op(8'd10, 8'd20, 1'b0, 3, edges, bcyc, seen);
        check("ign_done_seen", seen, 1);
        check("ign_latency", edges, 8);
        check("ign_result", result, 30);
        @(negedge clk);
        check("ign_no_restart", busy, 0);

        // Back-to-back: start asserted in the DONE cycle
        run_op(8'd1, 8'd2, 1'b0, -1, edges, bcyc, seen);
        check("b2b_first_result", result, 3);
        a = 8'd50; b = 8'd25; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy_no_gap", busy, 1);
        check("b2b_result_held", result, 3);
        seen = 1'b0; edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1; edges = i; break;
            end
        end
        check("b2b_done_seen", seen, 1);
        check("b2b_latency", edges, 8);
        check("b2b_result", result, 25);
        check("b2b_cout", cout, 1);

        // Make overflow set before the reset test
        run_op(8'h7F, 8'h01, 1'b0, -1, edges, bcyc, seen);
        check("pre_rst_ovf", overflow, 1);

        // Reset mid-RUN
        @(negedge clk);
        a = 8'd100; b = 8'd27; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("mid_rst_no_done", dcount, 0);
        check("mid_rst_result_after", result, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
